servo_pwm_bank: RTL

- Multi-channel servo PWM generator. All channels share one frame counter.
- Each channel has a programmable target pulse width in clock cycles. Targets are clamped to a safe range.
- Each channel's active width moves toward its target by a bounded step once per frame (slew limiting).
- Sits between the processor's memory-mapped write path and the servo pins. Replaces the fixed two-position pen-up/pen-down generator.

---
 rtl/servo_pwm_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared frame counter, clamped per-channel targets.
// Define SERVO_SLEW_EN for slew-limited ramping; otherwise active jumps to target each frame.
module servo_pwm_bank #(
    parameter  int unsigned CHANNELS   = 4,
    parameter  int unsigned SYS_FREQ   = 50000000,
    parameter  int unsigned PULSE_FREQ = 50,
    parameter  int unsigned WIDTH_BITS = 20,
    parameter  int unsigned MIN_WIDTH  = 50000,
    parameter  int unsigned MAX_WIDTH  = 250000,
    parameter  int unsigned STEP       = 2000,
    localparam int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [CH_BITS-1:0]    wr_ch,
    input  logic [WIDTH_BITS-1:0] wr_data,
    input  logic [CHANNELS-1:0]   ch_en,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  frame_start,
    output logic [CHANNELS-1:0]   settled
);

    localparam int unsigned PERIOD = SYS_FREQ / PULSE_FREQ;
    localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);
    localparam logic [WIDTH_BITS-1:0] MAX_W = WIDTH_BITS'(MAX_WIDTH);
    localparam logic [WIDTH_BITS-1:0] LAST  = WIDTH_BITS'(PERIOD - 1);

    // Elaboration-time guard against an unusable parameter set
    if (STEP == 0 || CHANNELS == 0 || CHANNELS > 16 || MIN_WIDTH > MAX_WIDTH ||
        MAX_WIDTH >= PERIOD || 64'(PERIOD) >= (64'(1) << WIDTH_BITS)) begin : g_param_check
        $error("servo_pwm_bank: illegal parameter set");
    end

    logic [WIDTH_BITS-1:0] cnt;
    logic [WIDTH_BITS-1:0] target     [CHANNELS];
    logic [WIDTH_BITS-1:0] active     [CHANNELS];
    logic [WIDTH_BITS-1:0] active_nxt [CHANNELS];
    logic [WIDTH_BITS-1:0] wr_clamped;
    logic                  frame_end;
    logic                  wr_hit;

    assign frame_end  = (cnt == LAST);
    assign wr_clamped = (wr_data < MIN_W) ? MIN_W :
                        (wr_data > MAX_W) ? MAX_W : wr_data;
    assign wr_hit     = wr_en && (32'(wr_ch) < CHANNELS);

`ifdef SERVO_SLEW_EN
    localparam int unsigned WX = WIDTH_BITS + 1;
    localparam logic [WX-1:0]         STEP_X = WX'(STEP);
    localparam logic [WIDTH_BITS-1:0] STEP_W = WIDTH_BITS'(STEP);

    // Move by STEP unless within STEP of target; compares are one bit wider so sums cannot wrap
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_nxt[i] = active[i];
            if ({1'b0, target[i]} > {1'b0, active[i]} + STEP_X) begin
                active_nxt[i] = active[i] + STEP_W;
            end else if ({1'b0, active[i]} > {1'b0, target[i]} + STEP_X) begin
                active_nxt[i] = active[i] - STEP_W;
            end else begin
                active_nxt[i] = target[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_nxt[i] = active[i];
            active_nxt[i] = target[i];
        end
    end
`endif

    always_comb begin
        settled = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            settled[i] = (active[i] == target[i]);
        end
    end

    // Active widths only change at the frame boundary, so pulses are never cut mid-frame
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= MIN_W;
                active[i] <= MIN_W;
            end
        end else begin
            cnt         <= frame_end ? '0 : cnt + WIDTH_BITS'(1);
            frame_start <= frame_end;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= ch_en[i] & (cnt < active[i]);
                if (frame_end) begin
                    active[i] <= active_nxt[i];
                end
            end
            if (wr_hit) begin
                target[wr_ch] <= wr_clamped;
            end
        end
    end

endmodule
